tlights_monitor: RTL and testbench
==================================

# tlights_monitor

Downstream checker for the traffic-light controller. It samples the controller's 3-bit `rag` output every clock and tracks the light sequence (RED → RED_AMBER → GREEN → AMBER → RED). It measures how long each phase lasts, counts complete cycles, and latches the first sequence or timing violation. It sits beside the controller in both the simulation bench and the FPGA top level, and feeds the status display.

## Interface
Parameters:
- `MIN_DWELL`, default 2: minimum legal cycles in any phase.
- `MAX_DWELL`, default 50: maximum legal cycles in any phase.
- `DW`, default 8: width of the dwell counter.
- `CW`, default 16: width of the completed-cycle counter.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rag` in 3: light state from the controller; bit 2 = red, bit 1 = amber, bit 0 = green.
- `err_clr` in 1: clears `err` and `err_code`.
- `locked` out 1: the monitor is tracking a legal phase.
- `phase` out 2: current phase, 0 = RED, 1 = RED_AMBER, 2 = GREEN, 3 = AMBER.
- `dwell` out DW: cycles spent in the current phase; saturates at 2^DW−1.
- `cycles` out CW: count of AMBER→RED transitions; wraps modulo 2^CW.
- `err` out 1: sticky error flag.
- `err_code` out 3: code of the first error since the last clear; 0 = none.

## Operation
- Legal codes: 100 = RED, 110 = RED_AMBER, 001 = GREEN, 010 = AMBER. Codes 000, 011, 101 and 111 are illegal.
- Unlocked:
  - Illegal code → stay unlocked.
  - Legal code → `locked`=1, `phase` takes that code's phase, `dwell`=1, and the `first` flag is set.
- Locked, each cycle:
  - Same code: `dwell` increments, saturating at 2^DW−1. When the next `dwell` value equals MAX_DWELL+1, raise LONG_DWELL. This fires once per phase.
  - Next code in the sequence: advance `phase` and set `dwell`=1.
    - If `first`=0 and the old `dwell` < MIN_DWELL, raise SHORT_DWELL.
    - Clear `first`.
    - If the transition is AMBER→RED, increment `cycles`.
  - Legal but out-of-order code: raise BAD_ORDER. `phase` takes the new code, `dwell`=1, `first` is set, and `locked` stays 1.
  - Illegal code: raise ILLEGAL_CODE and set `locked`=0. `phase` and `dwell` hold their values.
- Error codes: 1 = ILLEGAL_CODE, 2 = BAD_ORDER, 3 = SHORT_DWELL, 4 = LONG_DWELL.
  - Only one error can arise per cycle, because the conditions are exclusive by construction.
  - `err_code` is written only when `err`=0. The first error is retained until cleared.
  - If `err_clr` and a new error occur in the same cycle, the new error wins: `err`=1 and `err_code` = the new code.
- Reset values: `locked`=0, `phase`=0, `dwell`=0, `cycles`=0, `err`=0, `err_code`=0, `first`=0.
  - Reset mid-operation abandons all tracking.
  - `rst` dominates `err_clr` and any error.

## Timing
- All outputs are registered. A `rag` value sampled at edge N is reflected on the outputs after edge N, i.e. one cycle of latency.
- No combinational path from any input to any output.
- `err` rises in the same cycle as the `phase`/`dwell` update that caused it.
- SHORT_DWELL is checked against the `dwell` value held just before the transition edge.
- `dwell` saturation and LONG_DWELL are independent:
  - If MAX_DWELL ≥ 2^DW−1, LONG_DWELL never fires.
  - Otherwise it fires exactly once per phase.
- `cycles` wraps from 2^CW−1 to 0 without any flag.

## Structure
- Package `tlights_pkg` holds:
  - the `phase_t` enum and the rag code constants `RAG_RED`, `RAG_RED_AMBER`, `RAG_GREEN`, `RAG_AMBER`;
  - the `err_t` enum (ERR_NONE … ERR_LONG_DWELL);
  - the `next_phase()` and `rag_to_phase()` functions.
- One sub-module, `sat_counter` (parameter W; inputs `clr`, `inc`; output `q`), used for `dwell`.
- The rest is a single always_ff block plus a small combinational classifier: legal / same / next / out-of-order.

## Test plan
- Clean sequence, 4 cycles per phase starting at RED, run 3 full cycles:
  - `locked`=1 one cycle after the first sample;
  - `dwell` counts 1..4 in each phase;
  - `cycles`=3;
  - `err`=0.
- RED held for 1 cycle (not the first phase), then RED_AMBER → `err`=1, `err_code`=3, phase advances normally.
- `rag`=111 while locked → `err_code`=1 and `locked`=0. Then feed GREEN → relocks with `phase`=2, `dwell`=1. A short GREEN after relock raises no error.
- GREEN followed directly by RED → `err_code`=2, `phase`=0, `locked`=1. A second, later error leaves `err_code` at 2.
- MAX_DWELL=5: hold AMBER for 8 cycles → `err_code`=4 raised once, when `dwell` goes 5→6. Also assert `err_clr` on the same cycle as a new BAD_ORDER → `err`=1, `err_code`=2.
- Assert `rst` mid-GREEN with `err`=1 and `cycles`=2 → all outputs at reset values after the edge. The next legal code relocks.

Source files
------------

// File: rtl/tlights_pkg.sv
// Shared types and decode helpers for the traffic-light sequence monitor.
package tlights_pkg;

    typedef enum logic [1:0] {
        PH_RED       = 2'd0,
        PH_RED_AMBER = 2'd1,
        PH_GREEN     = 2'd2,
        PH_AMBER     = 2'd3
    } phase_t;

    localparam logic [2:0] RAG_RED       = 3'b100;
    localparam logic [2:0] RAG_RED_AMBER = 3'b110;
    localparam logic [2:0] RAG_GREEN     = 3'b001;
    localparam logic [2:0] RAG_AMBER     = 3'b010;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_ILLEGAL_CODE = 3'd1,
        ERR_BAD_ORDER    = 3'd2,
        ERR_SHORT_DWELL  = 3'd3,
        ERR_LONG_DWELL   = 3'd4
    } err_t;

    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            PH_RED:       n = PH_RED_AMBER;
            PH_RED_AMBER: n = PH_GREEN;
            PH_GREEN:     n = PH_AMBER;
            default:      n = PH_RED;
        endcase
        return n;
    endfunction

    function automatic logic rag_is_legal(input logic [2:0] rag);
        return (rag == RAG_RED) || (rag == RAG_RED_AMBER) ||
               (rag == RAG_GREEN) || (rag == RAG_AMBER);
    endfunction

    // Illegal codes map to PH_RED; callers must qualify with rag_is_legal().
    function automatic phase_t rag_to_phase(input logic [2:0] rag);
        phase_t p;
        case (rag)
            RAG_RED_AMBER: p = PH_RED_AMBER;
            RAG_GREEN:     p = PH_GREEN;
            RAG_AMBER:     p = PH_AMBER;
            default:       p = PH_RED;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tlights_monitor_sat_counter.sv
// Saturating up-counter; clr restarts the count, and clr with inc restarts at 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= inc ? W'(1) : '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/tlights_monitor.sv
// Checks the controller's rag output against the RED/RED_AMBER/GREEN/AMBER sequence,
// measures per-phase dwell, counts completed cycles and latches the first violation.
module tlights_monitor
    import tlights_pkg::*;
#(
    parameter int MIN_DWELL = 2,
    parameter int MAX_DWELL = 50,
    parameter int DW        = 8,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    rag,
    input  logic          err_clr,
    output logic          locked,
    output logic [1:0]    phase,
    output logic [DW-1:0] dwell,
    output logic [CW-1:0] cycles,
    output logic          err,
    output logic [2:0]    err_code
);

    // LONG_DWELL can only fire if dwell can actually reach MAX_DWELL+1 before saturating.
    localparam longint DWELL_SAT  = (longint'(1) << DW) - 1;
    localparam bit     LONG_ARMED = longint'(MAX_DWELL) < DWELL_SAT;

    logic   locked_q;
    logic   first_q;
    phase_t phase_q;
    logic [CW-1:0] cycles_q;
    logic   err_q;
    err_t   err_code_q;

    logic   code_legal;
    phase_t rag_phase;
    logic   code_same;
    logic   code_next;
    logic   code_ooo;
    logic   long_hit;
    err_t   err_new;
    logic   dwell_clr;
    logic   dwell_inc;

    always_comb begin
        code_legal = rag_is_legal(rag);
        rag_phase  = rag_to_phase(rag);
        code_same  = locked_q && code_legal && (rag_phase == phase_q);
        code_next  = locked_q && code_legal && (rag_phase == next_phase(phase_q));
        code_ooo   = locked_q && code_legal && !code_same && !code_next;
        long_hit   = LONG_ARMED && (dwell == DW'(MAX_DWELL));
    end

    always_comb begin
        err_new = ERR_NONE;
        if (locked_q) begin
            if (!code_legal) begin
                err_new = ERR_ILLEGAL_CODE;
            end else if (code_same && long_hit) begin
                err_new = ERR_LONG_DWELL;
            end else if (code_next && !first_q && (dwell < DW'(MIN_DWELL))) begin
                err_new = ERR_SHORT_DWELL;
            end else if (code_ooo) begin
                err_new = ERR_BAD_ORDER;
            end
        end
    end

    always_comb begin
        dwell_clr = (!locked_q && code_legal) || code_next || code_ooo;
        dwell_inc = dwell_clr || code_same;
    end

    sat_counter #(.W(DW)) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (dwell_clr),
        .inc (dwell_inc),
        .q   (dwell)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q   <= 1'b0;
            first_q    <= 1'b0;
            phase_q    <= PH_RED;
            cycles_q   <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            if (!locked_q) begin
                if (code_legal) begin
                    locked_q <= 1'b1;
                    phase_q  <= rag_phase;
                    first_q  <= 1'b1;
                end
            end else if (!code_legal) begin
                locked_q <= 1'b0;
            end else if (code_next) begin
                phase_q <= rag_phase;
                first_q <= 1'b0;
                if (phase_q == PH_AMBER) begin
                    cycles_q <= cycles_q + CW'(1);
                end
            end else if (code_ooo) begin
                phase_q <= rag_phase;
                first_q <= 1'b1;
            end

            // A fresh error beats a simultaneous clear.
            if ((err_new != ERR_NONE) && (!err_q || err_clr)) begin
                err_q      <= 1'b1;
                err_code_q <= err_new;
            end else if (err_clr) begin
                err_q      <= 1'b0;
                err_code_q <= ERR_NONE;
            end
        end
    end

    assign locked   = locked_q;
    assign phase    = phase_q;
    assign cycles   = cycles_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_tlights_monitor.sv
// Directed bench for tlights_monitor: a per-cycle reference model plus hand-computed spot checks.
module tb_tlights_monitor;

    localparam int MIN_DWELL = 2;
    localparam int MAX_DWELL = 5;
    localparam int DW        = 8;
    localparam int CW        = 16;
    localparam int DSAT      = (1 << DW) - 1;

    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] RA  = 3'b110;
    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] A   = 3'b010;

    logic          clk;
    logic          rst;
    logic [2:0]    rag;
    logic          err_clr;
    logic          locked;
    logic [1:0]    phase;
    logic [DW-1:0] dwell;
    logic [CW-1:0] cycles;
    logic          err;
    logic [2:0]    err_code;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 0;

    // reference model state
    int m_locked, m_phase, m_dwell, m_cycles, m_err, m_code, m_first;

    tlights_monitor #(
        .MIN_DWELL (MIN_DWELL),
        .MAX_DWELL (MAX_DWELL),
        .DW        (DW),
        .CW        (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rag      (rag),
        .err_clr  (err_clr),
        .locked   (locked),
        .phase    (phase),
        .dwell    (dwell),
        .cycles   (cycles),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int phase_of(input logic [2:0] c);
        case (c)
            3'b100:  return 0;
            3'b110:  return 1;
            3'b001:  return 2;
            3'b010:  return 3;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int p;
        int e;
        p = phase_of(rag);
        e = 0;
        if (rst) begin
            m_locked = 0; m_phase = 0; m_dwell = 0; m_cycles = 0;
            m_err = 0; m_code = 0; m_first = 0;
        end else begin
            if (m_locked == 0) begin
                if (p >= 0) begin
                    m_locked = 1; m_phase = p; m_dwell = 1; m_first = 1;
                end
            end else if (p < 0) begin
                e = 1;
                m_locked = 0;
            end else if (p == m_phase) begin
                if (m_dwell < DSAT) begin
                    m_dwell = m_dwell + 1;
                    if (m_dwell == MAX_DWELL + 1) e = 4;
                end
            end else if (p == (m_phase + 1) % 4) begin
                if (m_first == 0 && m_dwell < MIN_DWELL) e = 3;
                if (m_phase == 3) m_cycles = (m_cycles + 1) % (1 << CW);
                m_phase = p; m_dwell = 1; m_first = 0;
            end else begin
                e = 2;
                m_phase = p; m_dwell = 1; m_first = 1;
            end
            if (e != 0 && (m_err == 0 || err_clr)) begin
                m_err = 1; m_code = e;
            end else if (err_clr) begin
                m_err = 0; m_code = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_locked",   int'(locked),   m_locked);
            chk("model_phase",    int'(phase),    m_phase);
            chk("model_dwell",    int'(dwell),    m_dwell);
            chk("model_cycles",   int'(cycles),   m_cycles);
            chk("model_err",      int'(err),      m_err);
            chk("model_err_code", int'(err_code), m_code);
        end
    end

    // Holds code c for n samples; err_clr (if requested) accompanies only the first.
    task automatic drive(input logic [2:0] c, input int n, input logic clr = 1'b0);
        for (int i = 0; i < n; i++) begin
            rag     = c;
            err_clr = (i == 0) ? clr : 1'b0;
            @(negedge clk);
        end
        err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rag = 3'b000; err_clr = 1'b0;
        @(negedge clk);
        cmp_on = 1;
        @(negedge clk);
        chk("reset_locked", int'(locked), 0);
        chk("reset_dwell",  int'(dwell),  0);
        chk("reset_err",    int'(err),    0);
        rst = 1'b0;

        // clean sequence, 4 cycles per phase
        drive(R, 1);
        chk("lock_after_first", int'(locked), 1);
        chk("lock_dwell1",      int'(dwell),  1);
        drive(R, 3);
        chk("red_dwell4", int'(dwell), 4);
        for (int k = 0; k < 3; k++) begin
            drive(RA, 4); drive(G, 4); drive(A, 4); drive(R, 4);
        end
        chk("clean_cycles", int'(cycles), 3);
        chk("clean_err",    int'(err),    0);
        chk("clean_phase",  int'(phase),  0);

        // short RED
        drive(RA, 3); drive(G, 3); drive(A, 3); drive(R, 1); drive(RA, 1);
        chk("short_err",   int'(err),      1);
        chk("short_code",  int'(err_code), 3);
        chk("short_phase", int'(phase),    1);
        drive(G, 3);
        drive(G, 1, 1'b1);
        chk("clear_err",  int'(err),      0);
        chk("clear_code", int'(err_code), 0);

        // illegal code, then relock on GREEN
        drive(3'b111, 1);
        chk("illegal_code",   int'(err_code), 1);
        chk("illegal_locked", int'(locked),   0);
        chk("illegal_phase",  int'(phase),    2);
        drive(G, 1, 1'b1);
        chk("relock_phase", int'(phase),  2);
        chk("relock_dwell", int'(dwell),  1);
        drive(A, 2);
        chk("short_after_relock_err", int'(err), 0);

        // bad order GREEN -> RED, later error retained
        drive(R, 2); drive(RA, 2); drive(G, 2); drive(R, 1);
        chk("order_code",   int'(err_code), 2);
        chk("order_phase",  int'(phase),    0);
        chk("order_locked", int'(locked),   1);
        drive(3'b101, 1);
        chk("first_kept", int'(err_code), 2);

        // long AMBER
        drive(A, 1, 1'b1);
        drive(A, 7);
        chk("long_code",  int'(err_code), 4);
        chk("long_dwell", int'(dwell),    8);
        drive(A, 1, 1'b1);
        drive(A, 2);
        chk("long_once", int'(err), 0);

        // clear coincident with new BAD_ORDER
        drive(3'b111, 1);
        drive(A, 1);
        drive(G, 1, 1'b1);
        chk("clr_vs_new_err",  int'(err),      1);
        chk("clr_vs_new_code", int'(err_code), 2);

        // dwell saturation
        drive(G, 1, 1'b1);
        drive(G, 300);
        chk("sat_dwell", int'(dwell),    DSAT);
        chk("sat_code",  int'(err_code), 4);
        drive(G, 1, 1'b1);
        drive(G, 5);
        chk("sat_no_refire", int'(err), 0);

        // reset mid-GREEN with err set and two cycles counted
        rst = 1'b1; drive(G, 1); rst = 1'b0;
        drive(G, 4); drive(A, 1); drive(R, 4); drive(RA, 4);
        drive(G, 4); drive(A, 4); drive(R, 4); drive(RA, 4); drive(G, 3);
        chk("pre_rst_cycles", int'(cycles), 2);
        chk("pre_rst_err",    int'(err),    1);
        rst = 1'b1;
        drive(G, 1);
        chk("rst_locked",   int'(locked),   0);
        chk("rst_phase",    int'(phase),    0);
        chk("rst_dwell",    int'(dwell),    0);
        chk("rst_cycles",   int'(cycles),   0);
        chk("rst_err",      int'(err),      0);
        chk("rst_err_code", int'(err_code), 0);
        rst = 1'b0;
        drive(R, 1);
        chk("post_rst_locked", int'(locked), 1);
        chk("post_rst_dwell",  int'(dwell),  1);

        cmp_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
